// File: rtl/alu_op_encoder.sv
// rtl/alu_op_encoder.sv - packs ALU op requests into RV32I OP/OP-IMM words through a 2-entry output FIFO
// Optional: ALU_ENC_SHAMT_CHECK_EN rejects OP-IMM shifts whose imm[11:5] is non-zero.

`ifndef AluCntrBusBits
`define AluCntrBusBits 4
`endif
`ifndef DataBusBits
`define DataBusBits 32
`endif

module alu_op_encoder #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`AluCntrBusBits-1:0] in_alu_op,
  input  logic                       in_use_imm,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [11:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [`DataBusBits-1:0]    out_instr,
  output logic                       out_err,
  output logic [15:0]                enc_count
);

  localparam logic [`AluCntrBusBits-1:0] AluNop     = 4'd0;
  localparam logic [`AluCntrBusBits-1:0] AluSum     = 4'd1;
  localparam logic [`AluCntrBusBits-1:0] AluSub     = 4'd2;
  localparam logic [`AluCntrBusBits-1:0] AluLShift  = 4'd3;
  localparam logic [`AluCntrBusBits-1:0] AluLT      = 4'd4;
  localparam logic [`AluCntrBusBits-1:0] AluLTU     = 4'd5;
  localparam logic [`AluCntrBusBits-1:0] AluXor     = 4'd6;
  localparam logic [`AluCntrBusBits-1:0] AluRLShift = 4'd7;
  localparam logic [`AluCntrBusBits-1:0] AluRRShift = 4'd8;
  localparam logic [`AluCntrBusBits-1:0] AluOr      = 4'd9;
  localparam logic [`AluCntrBusBits-1:0] AluAnd     = 4'd10;

  localparam logic [6:0] OpcodeOp    = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm = 7'b0010011;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  logic        is_shift;
  logic        is_nop;
  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    legal    = 1'b1;
    is_shift = 1'b0;
    is_nop   = 1'b0;
    case (in_alu_op)
      AluNop:     is_nop = 1'b1;
      AluSum:     funct3 = 3'b000;
      AluSub:     begin funct3 = 3'b000; funct7 = 7'b0100000; legal = !in_use_imm; end
      AluLShift:  begin funct3 = 3'b001; is_shift = 1'b1; end
      AluLT:      funct3 = 3'b010;
      AluLTU:     funct3 = 3'b011;
      AluXor:     funct3 = 3'b100;
      AluRLShift: begin funct3 = 3'b101; is_shift = 1'b1; end
      AluRRShift: begin funct3 = 3'b101; funct7 = 7'b0100000; is_shift = 1'b1; end
      AluOr:      funct3 = 3'b110;
      AluAnd:     funct3 = 3'b111;
      default:    legal = 1'b0;
    endcase
`ifdef ALU_ENC_SHAMT_CHECK_EN
    if (is_shift && in_use_imm && (in_imm[11:5] != 7'd0))
      legal = 1'b0;
`endif
  end

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    if (!legal) begin
      enc_err = 1'b1;
    end else if (!is_nop) begin
      if (!in_use_imm)
        enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, OpcodeOp};
      else if (is_shift)
        enc_word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OpcodeOpImm};
      else
        enc_word = {in_imm, in_rs1, funct3, in_rd, OpcodeOpImm};
    end
  end

  // Head lives directly in the output registers; tail is the second FIFO slot.
  logic        tail_valid;
  logic [31:0] tail_word;
  logic        tail_err;
  logic        push;
  logic        pop;

  assign pop      = out_valid & out_ready;
  assign in_ready = !rst & (!tail_valid | pop);
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_err    <= 1'b0;
      tail_valid <= 1'b0;
      tail_word  <= '0;
      tail_err   <= 1'b0;
      enc_count  <= 16'd0;
    end else begin
      if (push)
        enc_count <= enc_count + 16'd1;
      case ({push, pop})
        2'b01: begin
          if (tail_valid) begin
            out_instr  <= tail_word;
            out_err    <= tail_err;
            tail_valid <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b10: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            out_err   <= enc_err;
          end else begin
            tail_valid <= 1'b1;
            tail_word  <= enc_word;
            tail_err   <= enc_err;
          end
        end
        2'b11: begin
          if (tail_valid) begin
            out_instr <= tail_word;
            out_err   <= tail_err;
            tail_word <= enc_word;
            tail_err  <= enc_err;
          end else begin
            out_instr <= enc_word;
            out_err   <= enc_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb/tb_alu_op_encoder.sv - directed-vector bench for alu_op_encoder
module tb_alu_op_encoder;

  localparam logic [3:0] AluNop = 4'd0, AluSum = 4'd1, AluSub = 4'd2, AluLShift = 4'd3;
  localparam logic [3:0] AluLTU = 4'd5, AluXor = 4'd6, AluRRShift = 4'd8, AluAnd = 4'd10;
  localparam logic [3:0] AluBad = 4'd15;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_op = '0;
  logic        in_use_imm = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;

  int total = 0;
  int bad = 0;

  alu_op_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic ui, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_alu_op = op; in_use_imm = ui; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] op, input logic ui, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    int n;
    n = 0;
    drive(op, ui, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic ui,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [11:0] imm, input logic [31:0] exp_word, input logic exp_err);
    push(op, ui, rd, rs1, rs2, imm);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_word"}, out_instr, exp_word);
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    pop_one();
    check({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(enc_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_instr", out_instr, 32'd0);
    check("reset_err", 32'(out_err), 32'd0);
    check("reset_count", 32'(enc_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    single("sum_reg", AluSum, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, 32'h003100B3, 1'b0);
    single("sub_reg", AluSub, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000, 32'h407302B3, 1'b0);
    single("sub_imm", AluSub, 1'b1, 5'd5, 5'd6, 5'd7, 12'h001, NOP, 1'b1);
    single("sum_imm", AluSum, 1'b1, 5'd1, 5'd0, 5'd9, 12'hFFF, 32'hFFF00093, 1'b0);
    single("srai", AluRRShift, 1'b1, 5'd2, 5'd2, 5'd0, 12'h004, 32'h40415113, 1'b0);
`ifdef ALU_ENC_SHAMT_CHECK_EN
    single("slli_bad", AluLShift, 1'b1, 5'd0, 5'd0, 5'd0, 12'h024, NOP, 1'b1);
`else
    single("slli_fix", AluLShift, 1'b1, 5'd0, 5'd0, 5'd0, 12'h024, 32'h00401013, 1'b0);
`endif
    single("and_reg", AluAnd, 1'b0, 5'd3, 5'd4, 5'd5, 12'h000, 32'h005271B3, 1'b0);
    single("xor_imm", AluXor, 1'b1, 5'd10, 5'd11, 5'd0, 12'h0FF, 32'h0FF5C513, 1'b0);
    single("illegal", AluBad, 1'b0, 5'd1, 5'd1, 5'd1, 12'h000, NOP, 1'b1);
    single("nop", AluNop, 1'b0, 5'd7, 5'd7, 5'd7, 12'h123, NOP, 1'b0);
    check("count_after_singles", 32'(enc_count), 32'd10);
    check("hold_instr", out_instr, NOP);

    reset_pulse();
    out_ready = 1'b0;
    push(AluSum, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
    push(AluSub, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
    drive(AluLTU, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
    in_valid = 1'b1;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_instr, 32'h003100B3);
    out_ready = 1'b1;
    #1;
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("order_b", out_instr, 32'h407302B3);
    check("order_b_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("order_c", out_instr, 32'h003130B3);
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold", out_instr, 32'h003130B3);
    check("burst_count", 32'(enc_count), 32'd3);
    out_ready = 1'b0;

    push(AluXor, 1'b1, 5'd10, 5'd11, 5'd0, 12'h0FF);
    push(AluAnd, 1'b0, 5'd3, 5'd4, 5'd5, 12'h000);
    reset_pulse();
    push(AluNop, 1'b0, 5'd0, 5'd0, 5'd0, 12'h000);
    check("post_rst_word", out_instr, NOP);
    check("post_rst_err", 32'(out_err), 32'd0);
    check("post_rst_count", 32'(enc_count), 32'd1);
    pop_one();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
